// File: rtl/fp_ctrl_pkg.sv
// Shared constants and types for the FP add arbiter slice.
// Operand word is {sign, exp[3:0], frac[7:0]} with a hidden leading one.
package fp_ctrl_pkg;

    localparam int OP_W     = 13;
    localparam int EXP_W    = 4;
    localparam int FRAC_W   = 8;
    localparam int SIGN_BIT = 12;
    localparam int EXP_MSB  = 11;
    localparam int EXP_LSB  = 8;
    localparam int FRAC_MSB = 7;
    localparam int FRAC_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_adder.sv
// Combinational adder for the 13-bit format: align, add/subtract, normalise.
// Exponent 0 encodes zero; results truncate, underflow to zero, saturate on overflow.
module fp_adder
    import fp_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] sum
);

    localparam int MW = FRAC_W + 1;  // mantissa with hidden one
    localparam int AW = 2 * MW;      // mantissa plus guard bits

    logic                    a_big;
    logic [OP_W-1:0]         big;
    logic [OP_W-1:0]         sml;
    logic [MW-1:0]           mant_big;
    logic [MW-1:0]           mant_sml;
    logic [EXP_W-1:0]        exp_diff;
    logic [AW-1:0]           al_big;
    logic [AW-1:0]           al_sml;
    logic [AW:0]             mag;
    logic [4:0]              pos;
    logic signed [6:0]       exp_r;
    logic [FRAC_W-1:0]       frac_r;

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    always_comb begin
        a_big    = a[OP_W-2:0] >= b[OP_W-2:0];
        big      = a_big ? a : b;
        sml      = a_big ? b : a;
        mant_big = (big[EXP_MSB:EXP_LSB] == '0) ? '0 : {1'b1, big[FRAC_MSB:0]};
        mant_sml = (sml[EXP_MSB:EXP_LSB] == '0) ? '0 : {1'b1, sml[FRAC_MSB:0]};
        exp_diff = big[EXP_MSB:EXP_LSB] - sml[EXP_MSB:EXP_LSB];
        al_big   = {mant_big, {MW{1'b0}}};
        al_sml   = {mant_sml, {MW{1'b0}}} >> exp_diff;

        if (big[SIGN_BIT] == sml[SIGN_BIT])
            mag = {1'b0, al_big} + {1'b0, al_sml};
        else
            mag = {1'b0, al_big} - {1'b0, al_sml};

        pos = '0;
        for (int i = 0; i <= AW; i++) begin
            if (mag[i]) pos = 5'(i);
        end

        // Leading one moves to bit AW; the eight bits below it form the fraction.
        frac_r = FRAC_W'((mag << (5'(AW) - pos)) >> (AW - FRAC_W));
        exp_r  = $signed({3'b000, big[EXP_MSB:EXP_LSB]}) + $signed({2'b00, pos}) - 7'sd17;

        sum = '0;
        if (mag != '0) begin
            if (exp_r > 7'sd15)
                sum = {big[SIGN_BIT], {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
            else if (exp_r >= 7'sd1)
                sum = {big[SIGN_BIT], exp_r[EXP_W-1:0], frac_r};
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for fp_adder: grant, latch operands,
// add from the latched copies, then pulse done to the winner.
module fp_add_arbiter
    import fp_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic [OP_W-1:0] opa0,
    input  logic [OP_W-1:0] opb0,
    input  logic            req1,
    input  logic [OP_W-1:0] opa1,
    input  logic [OP_W-1:0] opb1,
    output logic [1:0]      gnt,
    output logic            busy,
    output logic [OP_W-1:0] res,
    output logic [1:0]      done
);

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            last_q, last_d;
    logic [OP_W-1:0] opa_q, opa_d;
    logic [OP_W-1:0] opb_q, opb_d;
    logic [OP_W-1:0] res_q, res_d;
    logic [OP_W-1:0] add_sum;
    logic            win;

    fp_adder u_fp_adder (
        .a   (opa_q),
        .b   (opb_q),
        .sum (add_sum)
    );

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req0 || req1) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // On a tie the requester that did not win last time is served.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        gnt_d  = gnt_q;
        last_d = last_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt_d  = win ? 2'b10 : 2'b01;
                    last_d = win;
                    opa_d  = win ? opa1 : opa0;
                    opb_d  = win ? opb1 : opb0;
                end
            end
            ST_EXEC: res_d = add_sum;
            ST_DONE: gnt_d = 2'b00;
            default: gnt_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q  <= 2'b00;
            last_q <= 1'b1;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            res_q  <= res_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_EXEC) || (state_q == ST_DONE);
        done = (state_q == ST_DONE) ? gnt_q : 2'b00;
        gnt  = gnt_q;
        res  = res_q;
    end

endmodule
